// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets, status bit positions, FSM states.
// Build option UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package uart_tx_mmio_pkg;

    localparam int UART_DATA_OFS = 0;
    localparam int UART_STAT_OFS = 1;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-memory bus slice seen by the UART: address, store data/strobe and combinational load data.
interface uart_tx_mmio_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic [7:0] r_data;

    modport master (output addr, output w_data, output w_en, input r_data);
    modport slave  (input addr, input w_data, input w_en, output r_data);
endinterface

// File: rtl/uart_tx_mmio_tx_fifo.sv
// Small byte FIFO with wrap-bit pointers; read data is the entry at the read pointer, valid whenever not empty.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA stores feed a FIFO, an FSM sends 8N1 (8E1 with UART_TX_PARITY_EN) LSB first.
// STATUS load returns {4'b0, ovf, busy, full, empty}; a STATUS store with bit 3 set clears the sticky overflow.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int         CLK_DIV    = 16,
    parameter logic [7:0] BASE_ADDR  = 8'hF0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           tx,
    output logic           busy
);
    localparam logic [7:0] DATA_ADDR = 8'(BASE_ADDR + UART_DATA_OFS);
    localparam logic [7:0] STAT_ADDR = 8'(BASE_ADDR + UART_STAT_OFS);
    localparam int         CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          ovf_reg;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg;
`endif

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       data_wr, stat_wr, cnt_zero;

    assign data_wr  = bus.w_en && (bus.addr == DATA_ADDR);
    assign stat_wr  = bus.w_en && (bus.addr == STAT_ADDR);
    assign cnt_zero = (cnt_reg == '0);

    // A pop in the same cycle frees a slot, so a store to a full FIFO still lands.
    assign fifo_push = data_wr && (!fifo_full || fifo_pop);

    tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.w_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_reg <= 1'b0;
        end else if (stat_wr && bus.w_data[STAT_OVF]) begin
            ovf_reg <= 1'b0;
        end else if (data_wr && fifo_full && !fifo_pop) begin
            ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the whole byte before the shift register consumes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        parity_reg <= 1'b0;
        else if (fifo_pop) parity_reg <= even_parity(fifo_dout);
    end
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    cnt_next   = CNT_MAX;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (cnt_zero) begin
                    cnt_next   = CNT_MAX;
                    bit_next   = 3'd0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_zero) begin
                    cnt_next = CNT_MAX;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (cnt_zero) begin
                    cnt_next   = CNT_MAX;
                    state_next = ST_STOP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_zero) begin
                    // Chaining straight into the next start bit keeps back-to-back frames gap-free.
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        cnt_next   = CNT_MAX;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = (state_reg != ST_IDLE) || !fifo_empty;
        case (state_reg)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx = parity_reg;
`endif
            default:   tx = 1'b1;
        endcase
    end

    always_comb begin
        bus.r_data = 8'h00;
        if (bus.addr == STAT_ADDR) begin
            bus.r_data[STAT_EMPTY] = fifo_empty;
            bus.r_data[STAT_FULL]  = fifo_full;
            bus.r_data[STAT_BUSY]  = busy;
            bus.r_data[STAT_OVF]   = ovf_reg;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random stores against a frame-level reference model.
// Define UART_TX_PARITY_EN for both RTL and bench to exercise the parity build.
module tb_uart_tx_mmio;

    localparam int         CLK_DIV = 4;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] BASE    = 8'hF0;
    localparam logic [7:0] STAT    = 8'hF1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CLK_DIV;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = 10 * CLK_DIV;
    localparam bit PAR   = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic tx, busy;

    uart_tx_mmio_if bus_if ();

    uart_tx_mmio #(
        .CLK_DIV    (CLK_DIV),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Reference model: queue of waiting bytes, byte on the wire, clocks left in the current frame.
    logic [7:0] model_q [$];
    logic [7:0] cur_byte;
    int         frame_left;
    bit         ovf_m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int pos, b;
        if (frame_left == 0) return 1'b1;
        pos = FRAME - frame_left;
        b   = pos / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur_byte[b-1];
        if (PAR && b == 9) return ^cur_byte;
        return 1'b1;
    endfunction

    function automatic bit exp_busy();
        return (frame_left > 0) || (model_q.size() > 0);
    endfunction

    task automatic model_edge(input logic [7:0] a, input logic [7:0] d, input bit we);
        bit pop, acc;
        pop = (model_q.size() > 0) && (frame_left <= 1);
        if (pop) begin
            cur_byte   = model_q.pop_front();
            frame_left = FRAME;
        end else if (frame_left > 0) begin
            frame_left--;
        end
        acc = we && (a == BASE) && (model_q.size() < DEPTH);
        if (acc) model_q.push_back(d);
        if (we && a == STAT && d[3])      ovf_m = 1'b0;
        else if (we && a == BASE && !acc) ovf_m = 1'b1;
    endtask

    task automatic check_outputs(input logic [7:0] a);
        logic [7:0] exp_rd;
        exp_rd = 8'h00;
        if (a == STAT)
            exp_rd = {4'b0, ovf_m, exp_busy(), model_q.size() == DEPTH, model_q.size() == 0};
        check("tx", tx, exp_tx());
        check("busy", busy, exp_busy());
        check("r_data", bus_if.r_data, exp_rd);
    endtask

    task automatic step(input logic [7:0] a, input logic [7:0] d, input bit we);
        bus_if.addr   = a;
        bus_if.w_data = d;
        bus_if.w_en   = we;
        @(posedge clock);
        model_edge(a, d, we);
        #1;
        check_outputs(a);
        if (we)
            $display("store addr=%02h data=%02h queued=%0d ovf=%0b t=%0t", a, d, model_q.size(), ovf_m, $time);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(STAT, 8'h00, 1'b0);
    endtask

    task automatic async_reset();
        bus_if.w_en = 1'b0;
        bus_if.addr = STAT;
        #2 reset = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_status", bus_if.r_data, 8'h01);
        model_q.delete();
        frame_left = 0;
        ovf_m      = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat_a5;
        logic [7:0] rd;
        int         r;
        pat_a5        = 10'b1101001010;
        bus_if.addr   = 8'h00;
        bus_if.w_data = 8'h00;
        bus_if.w_en   = 1'b0;
        frame_left    = 0;
        ovf_m         = 1'b0;
        cur_byte      = 8'h00;

        #2;
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        #20 reset = 1'b1;

        // Status reads after reset
        step(STAT, 8'h00, 1'b0);
        check("stat_after_reset", bus_if.r_data, 8'h01);
        step(BASE, 8'h00, 1'b0);
        check("load_data_addr", bus_if.r_data, 8'h00);
        step(8'h10, 8'h00, 1'b0);
        check("load_other_addr", bus_if.r_data, 8'h00);

        // Single frame of 8'hA5
        step(BASE, 8'hA5, 1'b1);
        for (int i = 0; i < 41; i++) begin
            step(STAT, 8'h00, 1'b0);
            if (i < 40 && (i % CLK_DIV) == 2 && (i / CLK_DIV) < 10) begin
                rd = 8'(pat_a5[i / CLK_DIV]);
                check("a5_bit", tx, rd[0]);
            end
        end
        check("a5_busy_done", busy, 1'b0);

        // Back-to-back frames
        step(BASE, 8'h55, 1'b1);
        step(BASE, 8'h0F, 1'b1);
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            step(STAT, 8'h00, 1'b0);
            if (i == FRAME - 2) check("b2b_stop_end", tx, 1'b1);
            if (i == FRAME - 1) check("b2b_second_start", tx, 1'b0);
        end

        // FIFO fill, overflow and clear
        for (int i = 0; i < 5; i++) step(BASE, 8'($urandom), 1'b1);
        step(STAT, 8'h00, 1'b0);
        check("five_stores_status", bus_if.r_data, 8'h06);
        for (int i = 0; i < 6; i++) step(BASE, 8'($urandom), 1'b1);
        step(STAT, 8'h00, 1'b0);
        check("overflow_status", bus_if.r_data, 8'h0E);
        step(STAT, 8'h08, 1'b1);
        check("ovf_clear_status", bus_if.r_data, 8'h06);
        idle(5 * FRAME + 8);

        // Reset in the middle of a frame
        step(BASE, 8'hFF, 1'b1);
        idle(3 * CLK_DIV);
        async_reset();
        idle(FRAME + 4);
        check("no_resume_tx", tx, 1'b1);

`ifdef UART_TX_PARITY_EN
        step(BASE, 8'h07, 1'b1);
        for (int i = 0; i < FRAME + 1; i++) begin
            step(STAT, 8'h00, 1'b0);
            if (i == 9 * CLK_DIV + 2) check("parity_bit", tx, 1'b1);
            if (i == FRAME - 1)       check("parity_busy_last", busy, 1'b1);
            if (i == FRAME)           check("parity_busy_done", busy, 1'b0);
        end
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (n == 1500) begin
                async_reset();
            end else if (n >= 2000 && n < 2300) begin
                step(STAT, 8'h00, 1'b0);
            end else if (r < 8) begin
                step(BASE, 8'($urandom), 1'b1);
            end else if (r < 10) begin
                step(STAT, 8'($urandom), 1'b1);
            end else if (r < 40) begin
                step(STAT, 8'($urandom), 1'b0);
            end else begin
                step(8'($urandom), 8'($urandom), 1'b0);
            end
        end
        idle(DEPTH * FRAME + FRAME + 4);
        check("final_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
